coin_credit_controller: RTL and testbench
=========================================

Name: coin_credit_controller

Overview:
Upstream credit stage for the Mastermind arcade top level. Converts raw coin-insert and start-button inputs into the game count (NumGames) and partial credit (leftOver) shown on the seven-segment display. Grants one game to the game FSM per start request and holds the grant until that FSM reports game over.

Parameters:
PRICE, 4, credits per game; legal range 3..15 so one coin completes at most one game
MAX_GAMES, 7, saturation ceiling for NumGames; legal range 1..15

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
coinInserted  input  1  raw active-high coin button level, asynchronous to clock
CoinValue  input  2  coin type: 00 invalid, 01 circle = 1 credit, 10 triangle = 2, 11 pentagon = 3
StartGame  input  1  raw active-high start button level, asynchronous to clock
gameOver  input  1  single-cycle synchronous pulse from game FSM at end of a game
NumGames  output  4  games purchased and not yet started
leftOver  output  4  partial credit, 0..PRICE-1
gameGranted  output  1  one-cycle pulse: a game was consumed and started
gameActive  output  1  high from grant until gameOver
coinAccepted  output  1  one-cycle pulse: a coin was credited
coinRejected  output  1  one-cycle pulse: a coin was ignored (invalid type or saturated)

Behaviour:
- Reset (asynchronous, active-high): NumGames=0, leftOver=0, all pulses=0, gameActive=0, FSM=IDLE, synchronizer and edge flops=0.
- coinInserted and StartGame each pass through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev).
- One press gives one event, however long the button is held.
- Event latency: registered effects are visible after the 3rd rising clock edge following the input rise.
- CoinValue is sampled combinationally in the coin-event cycle. The operator must hold it stable before pressing.
- Coin event, value v (1..3), NumGames < MAX_GAMES:
  - sum = leftOver + v, at 5-bit width.
  - If sum >= PRICE: NumGames += 1 and leftOver = sum - PRICE.
  - Otherwise leftOver = sum.
  - coinAccepted pulses for 1 cycle.
- Coin event with CoinValue=00: no change; coinRejected pulses.
- Coin event with NumGames == MAX_GAMES (registered value): coin ignored, leftOver unchanged, coinRejected pulses.
- FSM IDLE:
  - Start event with registered NumGames > 0: NumGames -= 1, gameGranted pulses, gameActive=1, next state PLAYING.
  - Start event with NumGames == 0: ignored, no pulse.
- FSM PLAYING:
  - Start events are ignored.
  - gameOver pulse: gameActive=0, next state IDLE.
  - Coins are still accepted while PLAYING.
- gameOver while in IDLE is ignored.
- Simultaneous coin and start events in the same cycle:
  - Grant is decided on the registered NumGames; a coin arriving that same cycle cannot fund that grant.
  - Saturation is also decided on the registered NumGames.
  - Net update: NumGames_next = NumGames + inc - dec.
- Simultaneous gameOver and start event in PLAYING: return to IDLE; no grant that cycle.
- NumGames never wraps below 0 or above MAX_GAMES. leftOver always stays below PRICE.
- Reset asserted mid-operation clears everything immediately, including an in-flight game and pulses in progress. Any edge already in the synchronizer is lost.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset release, idle 10 cycles -> NumGames=0, leftOver=0, gameActive=0, no pulses.
- Coins 3 then 2 (PRICE=4) -> after first: leftOver=3, NumGames=0. After second: NumGames=1, leftOver=1. coinAccepted pulses twice, 1 cycle each.
- Hold coinInserted high for 50 cycles with value 01 -> exactly one credit (leftOver=1). CoinValue=00 press -> coinRejected pulses, state unchanged.
- Buy 7 games, then insert a value-3 coin -> coinRejected pulses, NumGames=7, leftOver unchanged. Then start -> gameGranted pulses, NumGames=6, gameActive=1. Second start while PLAYING -> ignored. gameOver -> gameActive=0.
- NumGames=1, leftOver=3, coin value 1 and start events land in the same cycle -> gameGranted pulses, NumGames=1, leftOver=0. Repeat from NumGames=0, leftOver=3 -> no grant, NumGames=1.
- Assert reset during PLAYING with NumGames=4 -> all outputs 0 within the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/coin_credit_controller.sv
// Coin/start credit stage: synchronizes raw buttons, accumulates coin credit into
// purchased games, and grants one game per start until the game FSM reports game over.
module coin_credit_controller #(
    parameter int unsigned PRICE     = 4,
    parameter int unsigned MAX_GAMES = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coinInserted,
    input  logic [1:0] CoinValue,
    input  logic       StartGame,
    input  logic       gameOver,
    output logic [3:0] NumGames,
    output logic [3:0] leftOver,
    output logic       gameGranted,
    output logic       gameActive,
    output logic       coinAccepted,
    output logic       coinRejected
);

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    localparam logic [4:0] PRICE_W = 5'(PRICE);
    localparam logic [3:0] MAX_W   = 4'(MAX_GAMES);

    state_t     state;
    state_t     state_next;

    logic       coin_s1;
    logic       coin_s2;
    logic       coin_prev;
    logic       start_s1;
    logic       start_s2;
    logic       start_prev;
    logic       coin_evt;
    logic       start_evt;

    logic       saturated;
    logic       coin_ok;
    logic       coin_bad;
    logic       inc;
    logic       grant;
    logic [4:0] sum;
    logic [3:0] left_next;
    logic [3:0] games_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coin_s1    <= 1'b0;
            coin_s2    <= 1'b0;
            coin_prev  <= 1'b0;
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            coin_s1    <= coinInserted;
            coin_s2    <= coin_s1;
            coin_prev  <= coin_s2;
            start_s1   <= StartGame;
            start_s2   <= start_s1;
            start_prev <= start_s2;
        end
    end

    assign coin_evt  = coin_s2 & ~coin_prev;
    assign start_evt = start_s2 & ~start_prev;

    // Saturation uses the registered count, so a same-cycle grant cannot reopen room.
    always_comb begin
        saturated = (NumGames == MAX_W);
        coin_ok   = coin_evt && (CoinValue != 2'b00) && !saturated;
        coin_bad  = coin_evt && !coin_ok;
        sum       = {1'b0, leftOver} + {3'b000, CoinValue};
        inc       = coin_ok && (sum >= PRICE_W);
        left_next = leftOver;
        if (coin_ok) begin
            if (inc) begin
                left_next = 4'(sum - PRICE_W);
            end else begin
                left_next = sum[3:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (start_evt && (NumGames != 4'd0)) begin
                    grant      = 1'b1;
                    state_next = PLAYING;
                end
            end
            PLAYING: begin
                if (gameOver) begin
                    state_next = IDLE;
                end
            end
        endcase
        games_next = NumGames + {3'b000, inc} - {3'b000, grant};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            NumGames     <= '0;
            leftOver     <= '0;
            gameGranted  <= 1'b0;
            coinAccepted <= 1'b0;
            coinRejected <= 1'b0;
        end else begin
            NumGames     <= games_next;
            leftOver     <= left_next;
            gameGranted  <= grant;
            coinAccepted <= coin_ok;
            coinRejected <= coin_bad;
        end
    end

    assign gameActive = (state == PLAYING);

endmodule

// File: tb/tb_coin_credit_controller.sv
// Self-checking bench for coin_credit_controller (PRICE=4, MAX_GAMES=7): vector table
// through a scoreboard queue, plus held-button and asynchronous-reset sequences.
module tb_coin_credit_controller;

    logic       clock;
    logic       reset;
    logic       coinInserted;
    logic [1:0] CoinValue;
    logic       StartGame;
    logic       gameOver;
    logic [3:0] NumGames;
    logic [3:0] leftOver;
    logic       gameGranted;
    logic       gameActive;
    logic       coinAccepted;
    logic       coinRejected;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit       coin;
        bit [1:0] val;
        bit       start;
        bit       go;
        bit       rst_mid;
        int       games;
        int       left;
        bit       acc;
        bit       rej;
        bit       grant;
        bit       active;
    } vec_t;

    vec_t vecs[34];
    vec_t exp_q[$];

    coin_credit_controller #(
        .PRICE     (4),
        .MAX_GAMES (7)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .coinInserted (coinInserted),
        .CoinValue    (CoinValue),
        .StartGame    (StartGame),
        .gameOver     (gameOver),
        .NumGames     (NumGames),
        .leftOver     (leftOver),
        .gameGranted  (gameGranted),
        .gameActive   (gameActive),
        .coinAccepted (coinAccepted),
        .coinRejected (coinRejected)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " NumGames"}, int'(NumGames), 0);
        chk({tag, " leftOver"}, int'(leftOver), 0);
        chk({tag, " gameGranted"}, int'(gameGranted), 0);
        chk({tag, " gameActive"}, int'(gameActive), 0);
        chk({tag, " coinAccepted"}, int'(coinAccepted), 0);
        chk({tag, " coinRejected"}, int'(coinRejected), 0);
    endtask

    // Button rises before edge 1; the event is registered at edge 3.
    // gameOver is held across edge 3 so it coincides with the synchronized event.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        string t;
        t = $sformatf("vec%0d", idx);
        @(negedge clock);
        coinInserted = v.coin;
        CoinValue    = v.val;
        StartGame    = v.start;
        exp_q.push_back(v);
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        gameOver = v.go;
        @(posedge clock);
        @(negedge clock);
        gameOver = 1'b0;
        e = exp_q.pop_front();
        chk({t, " NumGames"}, int'(NumGames), e.games);
        chk({t, " leftOver"}, int'(leftOver), e.left);
        chk({t, " coinAccepted"}, int'(coinAccepted), int'(e.acc));
        chk({t, " coinRejected"}, int'(coinRejected), int'(e.rej));
        chk({t, " gameGranted"}, int'(gameGranted), int'(e.grant));
        chk({t, " gameActive"}, int'(gameActive), int'(e.active));
        if (e.rst_mid) begin
            #2;
            reset        = 1'b1;
            coinInserted = 1'b0;
            StartGame    = 1'b0;
            #1;
            chk_all_zero({t, " async-reset"});
            @(negedge clock);
            reset = 1'b0;
        end else begin
            @(negedge clock);
            chk({t, " acc-1cyc"}, int'(coinAccepted), 0);
            chk({t, " rej-1cyc"}, int'(coinRejected), 0);
            chk({t, " grant-1cyc"}, int'(gameGranted), 0);
            coinInserted = 1'b0;
            StartGame    = 1'b0;
        end
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int acc_cnt;
        int rej_cnt;
        //          c  v  s  g  r   G  L  acc rej gr act
        vecs[0]  = '{1, 3, 0, 0, 0, 0, 3, 1, 0, 0, 0};
        vecs[1]  = '{1, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
        vecs[3]  = '{1, 3, 0, 0, 0, 2, 0, 1, 0, 0, 0};
        vecs[4]  = '{1, 3, 0, 0, 0, 2, 3, 1, 0, 0, 0};
        vecs[5]  = '{1, 3, 0, 0, 0, 3, 2, 1, 0, 0, 0};
        vecs[6]  = '{1, 3, 0, 0, 0, 4, 1, 1, 0, 0, 0};
        vecs[7]  = '{1, 3, 0, 0, 0, 5, 0, 1, 0, 0, 0};
        vecs[8]  = '{1, 3, 0, 0, 0, 5, 3, 1, 0, 0, 0};
        vecs[9]  = '{1, 3, 0, 0, 0, 6, 2, 1, 0, 0, 0};
        vecs[10] = '{1, 3, 0, 0, 0, 7, 1, 1, 0, 0, 0};
        vecs[11] = '{1, 3, 0, 0, 0, 7, 1, 0, 1, 0, 0};
        vecs[12] = '{1, 1, 0, 0, 0, 7, 1, 0, 1, 0, 0};
        vecs[13] = '{0, 0, 1, 0, 0, 6, 1, 0, 0, 1, 1};
        vecs[14] = '{0, 0, 1, 0, 0, 6, 1, 0, 0, 0, 1};
        vecs[15] = '{1, 1, 0, 0, 0, 6, 2, 1, 0, 0, 1};
        vecs[16] = '{0, 0, 0, 1, 0, 6, 2, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 1, 0, 6, 2, 0, 0, 0, 0};
        vecs[18] = '{0, 0, 1, 0, 0, 5, 2, 0, 0, 1, 1};
        vecs[19] = '{0, 0, 0, 1, 0, 5, 2, 0, 0, 0, 0};
        vecs[20] = '{0, 0, 1, 0, 1, 4, 2, 0, 0, 1, 1};
        vecs[21] = '{1, 3, 0, 0, 0, 0, 3, 1, 0, 0, 0};
        vecs[22] = '{1, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        vecs[23] = '{1, 2, 0, 0, 0, 1, 3, 1, 0, 0, 0};
        vecs[24] = '{1, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1};
        vecs[25] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        vecs[26] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[27] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[28] = '{1, 3, 0, 0, 0, 0, 3, 1, 0, 0, 0};
        vecs[29] = '{1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0};
        vecs[30] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[31] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[32] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[33] = '{1, 2, 0, 0, 0, 0, 2, 1, 0, 0, 0};

        reset        = 1'b1;
        coinInserted = 1'b0;
        CoinValue    = 2'b00;
        StartGame    = 1'b0;
        gameOver     = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk_all_zero("reset-idle");

        // Long press: a single credit regardless of hold time.
        CoinValue    = 2'b01;
        coinInserted = 1'b1;
        acc_cnt = 0;
        rej_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (coinAccepted) acc_cnt++;
            if (coinRejected) rej_cnt++;
        end
        coinInserted = 1'b0;
        repeat (4) @(negedge clock);
        chk("held accept count", acc_cnt, 1);
        chk("held reject count", rej_cnt, 0);
        chk("held leftOver", int'(leftOver), 1);
        chk("held NumGames", int'(NumGames), 0);

        // Continue from leftOver=1: first table coin of 3 gives sum 4 -> one game.
        vecs[0] = '{1, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0};
        vecs[1] = '{1, 3, 0, 0, 0, 1, 3, 1, 0, 0, 0};
        vecs[2] = '{1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0};
        vecs[3] = '{1, 2, 0, 0, 0, 2, 1, 1, 0, 0, 0};
        vecs[4] = '{1, 2, 0, 0, 0, 2, 3, 1, 0, 0, 0};
        vecs[5] = '{1, 3, 0, 0, 0, 3, 2, 1, 0, 0, 0};

        for (int i = 0; i < 34; i++) begin
            apply(i, vecs[i]);
        end

        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
